wave_frame_aligner: RTL and testbench

Front-end stage feeding the waveform classifier. Takes raw offset-binary ADC samples, removes the DC offset, and phase-aligns each frame to a rising mid-level crossing. Decimates by a programmable ratio so that exactly 128 signed 12-bit samples are emitted per frame, starting at a known point in the signal period. The classifier then correlates one aligned period at a time against its 128-entry reference tables.

---
 rtl/wave_frame_aligner.sv | 210 +++++++++++++++++++++
 tb/tb_wave_frame_aligner.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_frame_aligner.sv
// Removes DC offset from offset-binary ADC samples and emits FRAME_LEN decimated samples per frame,
// aligned to a rising mid-level crossing. Build macro WAVE_ALIGN_DC_EN enables per-frame DC tracking.
module wave_frame_aligner #(
    parameter int unsigned FRAME_LEN = 128,
    parameter int unsigned HYST      = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data,
    input  logic        adc_valid,
    input  logic [15:0] dec_ratio,
    output logic [11:0] out_data,
    output logic        out_valid,
    output logic        frame_start,
    output logic        forced
);

    localparam int unsigned DW   = 12;
    localparam int unsigned CW   = DW + 2;
    localparam int unsigned RW   = 16;
    localparam int unsigned FL_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_ARM     = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic [DW-1:0]        MID      = 12'd2048;
    localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [FL_W-1:0]      LAST_IDX = FL_W'(FRAME_LEN - 1);
    localparam logic signed [DW:0]   SAT_MAX  = 13'sd2047;
    localparam logic signed [DW:0]   SAT_MIN  = -13'sd2048;

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [RW-1:0]   dec_q, dec_d;
    logic [RW-1:0]   dcnt_q, dcnt_d;
    logic [FL_W-1:0] scnt_q, scnt_d;
    logic            forced_q, forced_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_start_q, frame_start_d;

    logic [DW-1:0]        offset;
    logic [CW-1:0]        adc_ext, off_ext, hyst_ext;
    logic                 below_lo_c, above_hi_c;
    logic signed [DW:0]   diff_c;
    logic [DW-1:0]        sat_c;
    logic                 emit_c, start_c, force_start_c;

    // Threshold compares are done unsigned in a wider space so offset +/- HYST never wraps.
    assign adc_ext    = CW'(adc_data);
    assign off_ext    = CW'(offset);
    assign hyst_ext   = CW'(HYST);
    assign below_lo_c = (adc_ext + hyst_ext) < off_ext;
    assign above_hi_c = adc_ext >= (off_ext + hyst_ext);

    assign diff_c = $signed({1'b0, adc_data}) - $signed({1'b0, offset});

    always_comb begin
        sat_c = diff_c[DW-1:0];
        if (diff_c > SAT_MAX) begin
            sat_c = SAT_MAX[DW-1:0];
        end else if (diff_c < SAT_MIN) begin
            sat_c = SAT_MIN[DW-1:0];
        end
    end

    // Next-state and output decode; only accepted samples advance anything.
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        dec_d         = dec_q;
        dcnt_d        = dcnt_q;
        scnt_d        = scnt_q;
        forced_d      = forced_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        emit_c        = 1'b0;
        start_c       = 1'b0;
        force_start_c = 1'b0;

        if (adc_valid) begin
            unique case (state_q)
                ST_ARM: begin
                    if (tcnt_q == TO_MAX) begin
                        force_start_c = 1'b1;
                    end else begin
                        if (below_lo_c) begin
                            state_d = ST_WAIT_HI;
                        end
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                ST_WAIT_HI: begin
                    if (above_hi_c) begin
                        start_c = 1'b1;
                    end else if (tcnt_q == TO_MAX) begin
                        force_start_c = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (dcnt_q == dec_q) begin
                        emit_c = 1'b1;
                        dcnt_d = RW'(1);
                        if (scnt_q == LAST_IDX) begin
                            state_d = ST_ARM;
                            scnt_d  = '0;
                        end else begin
                            scnt_d = scnt_q + FL_W'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = ST_ARM;
                end
            endcase

            // The triggering sample is output sample 0 of the new frame.
            if (start_c || force_start_c) begin
                emit_c        = 1'b1;
                frame_start_d = 1'b1;
                state_d       = ST_CAPTURE;
                tcnt_d        = '0;
                dcnt_d        = RW'(1);
                scnt_d        = FL_W'(1);
                dec_d         = (dec_ratio == '0) ? RW'(1) : dec_ratio;
                forced_d      = force_start_c;
            end

            if (emit_c) begin
                out_valid_d = 1'b1;
                out_data_d  = sat_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ARM;
            tcnt_q        <= '0;
            dec_q         <= '0;
            dcnt_q        <= '0;
            scnt_q        <= '0;
            forced_q      <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            dec_q         <= dec_d;
            dcnt_q        <= dcnt_d;
            scnt_q        <= scnt_d;
            forced_q      <= forced_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef WAVE_ALIGN_DC_EN
    localparam int unsigned ACC_W = DW + FL_W;

    logic [DW-1:0]    offset_q, offset_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum_c;
    logic             frame_end_c;

    // Mean of the emitted raw samples becomes the offset for the next frame.
    assign frame_end_c = emit_c && (state_q == ST_CAPTURE) && (scnt_q == LAST_IDX);
    assign acc_sum_c   = acc_q + ACC_W'(adc_data);

    always_comb begin
        acc_d    = acc_q;
        offset_d = offset_q;
        if (frame_end_c) begin
            acc_d    = '0;
            offset_d = DW'(acc_sum_c >> FL_W);
        end else if (emit_c) begin
            acc_d = acc_sum_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= MID;
            acc_q    <= '0;
        end else begin
            offset_q <= offset_d;
            acc_q    <= acc_d;
        end
    end

    assign offset = offset_q;
`else
    assign offset = MID;
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign forced      = forced_q;

endmodule

// File: tb/tb_wave_frame_aligner.sv
// Scoreboard bench for wave_frame_aligner: a reference model queues expected outputs per driven sample.
module tb_wave_frame_aligner;

    localparam int FRAME_LEN = 128;
    localparam int HYST      = 16;
    localparam int TIMEOUT   = 65535;
    localparam real PI       = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [15:0] dec_ratio;
    logic [11:0] out_data;
    logic        out_valid;
    logic        frame_start;
    logic        forced;

    int     tests = 0;
    int     fails = 0;
    longint cyc   = 0;

    typedef struct {
        int     data;
        bit     fs;
        bit     frc;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     obs_data[$];
    bit     obs_fs[$];
    bit     obs_frc[$];
    longint obs_cyc[$];

    int m_state, m_off, m_tcnt, m_dcnt, m_dec, m_scnt, m_acc;
    bit m_forced;

    wave_frame_aligner #(
        .FRAME_LEN(FRAME_LEN),
        .HYST(HYST),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .dec_ratio(dec_ratio),
        .out_data(out_data),
        .out_valid(out_valid),
        .frame_start(frame_start),
        .forced(forced)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_state  = 0;
        m_off    = 2048;
        m_tcnt   = 0;
        m_dcnt   = 0;
        m_dec    = 1;
        m_scnt   = 0;
        m_acc    = 0;
        m_forced = 1'b0;
    endfunction

    function automatic void clear_obs();
        obs_data.delete();
        obs_fs.delete();
        obs_frc.delete();
        obs_cyc.delete();
    endfunction

    // Reference behaviour for one accepted sample.
    task automatic model_sample(input int d);
        bit   start, frc, emit, last;
        int   v;
        exp_t e;
        start = 1'b0; frc = 1'b0; emit = 1'b0; last = 1'b0;
        case (m_state)
            0: begin
                if (m_tcnt == TIMEOUT) begin
                    start = 1'b1; frc = 1'b1;
                end else begin
                    if (d < m_off - HYST) m_state = 1;
                    m_tcnt++;
                end
            end
            1: begin
                if (d >= m_off + HYST) start = 1'b1;
                else if (m_tcnt == TIMEOUT) begin
                    start = 1'b1; frc = 1'b1;
                end else m_tcnt++;
            end
            default: begin
                if (m_dcnt >= m_dec) begin
                    emit   = 1'b1;
                    m_dcnt = 1;
                    m_scnt++;
                    if (m_scnt == FRAME_LEN) begin
                        last = 1'b1; m_state = 0; m_scnt = 0;
                    end
                end else m_dcnt++;
            end
        endcase
        if (start) begin
            emit     = 1'b1;
            m_state  = 2;
            m_tcnt   = 0;
            m_dcnt   = 1;
            m_scnt   = 1;
            m_dec    = (dec_ratio == 16'd0) ? 1 : int'(dec_ratio);
            m_forced = frc;
        end
        if (emit) begin
            v = d - m_off;
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            e.data = v; e.fs = start; e.frc = m_forced; e.cyc = cyc + 1;
            exp_q.push_back(e);
            m_acc += d;
            if (last) begin
`ifdef WAVE_ALIGN_DC_EN
                m_off = m_acc / FRAME_LEN;
`endif
                m_acc = 0;
            end
        end
    endtask

    task automatic step(input int d, input bit v);
        @(posedge clk);
        #1;
        adc_data  = 12'(d);
        adc_valid = v;
        if (v) model_sample(d);
    endtask

    task automatic drain();
        repeat (4) step(0, 1'b0);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; adc_valid = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every out_valid pops one expected entry, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (frame_start) begin
                tests++;
                if (!out_valid) begin
                    fails++;
                    $display("FAIL frame_start_alone: out_valid=%0b required 1", out_valid);
                end
            end
            if (out_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: data=%0d at cycle %0d, required no output", $signed(out_data), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ($signed(out_data) !== e.data || frame_start !== e.fs || forced !== e.frc || cyc !== e.cyc) begin
                        fails++;
                        $display("FAIL output: data=%0d fs=%0b forced=%0b cyc=%0d, required data=%0d fs=%0b forced=%0b cyc=%0d",
                                 $signed(out_data), frame_start, forced, cyc, e.data, e.fs, e.frc, e.cyc);
                    end
                end
                obs_data.push_back(int'($signed(out_data)));
                obs_fs.push_back(frame_start);
                obs_frc.push_back(forced);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic test_reset();
        bit bad;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
        tests++; if (out_data !== 12'd0) begin fails++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL rst_frame_start: got %0b required 0", frame_start); end
        tests++; if (forced !== 1'b0) begin fails++; $display("FAIL rst_forced: got %0b required 0", forced); end
        @(posedge clk);
        #1;
        rst = 1'b0;

        dec_ratio = 16'd1;
        clear_obs();
        step(100, 1'b1);
        for (int i = 0; i < 20; i++) step(3000, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midframe_drop: out_valid=%0b required 0", out_valid); end
        tests++; if (obs_data.size() != 19) begin fails++; $display("FAIL midframe_count: got %0d outputs required 19", obs_data.size()); end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            adc_valid = 1'b1;
            adc_data  = (i % 2 == 0) ? 12'd0 : 12'd3000;
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        tests++; if (bad) begin fails++; $display("FAIL held_reset: out_valid=1 seen, required 0"); end
        @(posedge clk);
        #1;
        rst = 1'b0; adc_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_data !== 12'd0) begin fails++; $display("FAIL release_out_data: got %0d required 0", out_data); end
        tests++; if (forced !== 1'b0) begin fails++; $display("FAIL release_forced: got %0b required 0", forced); end
        for (int i = 0; i < 40; i++) step(3000, 1'b1);
        drain();
        tests++; if (obs_data.size() != 19) begin fails++; $display("FAIL no_rearm: got %0d outputs required 19", obs_data.size()); end
    endtask

    task automatic test_sine_dec4();
        real r;
        do_reset();
        dec_ratio = 16'd4;
        clear_obs();
        for (int n = 0; n < 2200; n++) begin
            r = 2048.0 + 1000.0 * $sin(2.0 * PI * n / 512.0);
            step($rtoi(r + 0.5), 1'b1);
        end
        drain();
        tests++; if (obs_data.size() != 256) begin fails++; $display("FAIL sine_count: got %0d required 256", obs_data.size()); end
        if (obs_data.size() >= 256) begin
            tests++;
            if (!obs_fs[0] || !obs_fs[128]) begin fails++; $display("FAIL sine_frame_start: fs0=%0b fs128=%0b required 1 1", obs_fs[0], obs_fs[128]); end
            tests++;
            if (obs_data[0] < 16 || obs_data[0] > 52) begin fails++; $display("FAIL sine_first0: got %0d required 16..52", obs_data[0]); end
            tests++;
            if (obs_data[128] < 16 || obs_data[128] > 52) begin fails++; $display("FAIL sine_first1: got %0d required 16..52", obs_data[128]); end
        end
    endtask

    task automatic test_saturation();
        int bad;
        do_reset();
        dec_ratio = 16'd0;
        clear_obs();
        for (int i = 0; i < 130; i++) step((i % 2 == 1) ? 4095 : 0, 1'b1);
        drain();
        tests++; if (obs_data.size() != 128) begin fails++; $display("FAIL sat_count: got %0d required 128", obs_data.size()); end
        bad = 0;
        for (int k = 0; k < obs_data.size(); k++)
            if (obs_data[k] != ((k % 2 == 0) ? 2047 : -2048)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL sat_values: %0d samples off the 2047/-2048 pattern, required 0", bad); end
    endtask

    task automatic test_gapped();
        do_reset();
        dec_ratio = 16'd3;
        clear_obs();
        step(100, 1'b1);
        step(0, 1'b0);
        for (int k = 1; k <= 390; k++) begin
            step(2100 + k, 1'b1);
            step(0, 1'b0);
            if (k == 20) dec_ratio = 16'd5;
        end
        drain();
        tests++; if (obs_data.size() != 128) begin fails++; $display("FAIL gap_count: got %0d required 128", obs_data.size()); end
        if (obs_data.size() >= 128) begin
            tests++; if (obs_data[0] != 53) begin fails++; $display("FAIL gap_s0: got %0d required 53", obs_data[0]); end
            tests++; if (obs_data[1] != 56) begin fails++; $display("FAIL gap_s1: got %0d required 56", obs_data[1]); end
            tests++; if (obs_data[127] != 434) begin fails++; $display("FAIL gap_s127: got %0d required 434", obs_data[127]); end
            tests++; if (obs_cyc[1] - obs_cyc[0] != 6) begin fails++; $display("FAIL gap_spacing: got %0d cycles required 6", obs_cyc[1] - obs_cyc[0]); end
        end
    endtask

    task automatic test_back_to_back_dc();
        int bad, hi, lo;
`ifdef WAVE_ALIGN_DC_EN
        hi = 1000;  lo = -1000;
`else
        hi = 1452;  lo = -548;
`endif
        do_reset();
        dec_ratio = 16'd1;
        clear_obs();
        for (int i = 0; i < 288; i++) step(((i / 8) % 2 == 0) ? 1500 : 3500, 1'b1);
        drain();
        tests++; if (obs_data.size() != 256) begin fails++; $display("FAIL dc_count: got %0d required 256", obs_data.size()); end
        if (obs_data.size() >= 256) begin
            tests++; if (obs_cyc[127] - obs_cyc[0] != 127) begin fails++; $display("FAIL b2b_span: got %0d cycles required 127", obs_cyc[127] - obs_cyc[0]); end
            tests++; if (obs_data[0] != 1452) begin fails++; $display("FAIL dc_first: got %0d required 1452", obs_data[0]); end
            bad = 0;
            for (int j = 0; j < 128; j++)
                if (obs_data[128 + j] != (((j / 8) % 2 == 0) ? hi : lo)) bad++;
            tests++; if (bad != 0) begin fails++; $display("FAIL dc_frame2: %0d samples off %0d/%0d, required 0", bad, hi, lo); end
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        dec_ratio = 16'd1;
        clear_obs();
        for (int i = 0; i < TIMEOUT; i++) step(2048, 1'b1);
        step(2048, 1'b1);
        @(negedge clk);
        #1;
        tests++; if (obs_data.size() != 0) begin fails++; $display("FAIL timeout_early: got %0d outputs required 0", obs_data.size()); end
        for (int i = 0; i < 127; i++) step(2048, 1'b1);
        step(0, 1'b1);
        for (int i = 0; i < 10; i++) step(3000, 1'b1);
        drain();
        tests++; if (obs_data.size() != 138) begin fails++; $display("FAIL timeout_count: got %0d required 138", obs_data.size()); end
        if (obs_data.size() >= 138) begin
            bad = 0;
            for (int k = 0; k < 128; k++)
                if (obs_data[k] != 0 || !obs_frc[k]) bad++;
            tests++; if (bad != 0) begin fails++; $display("FAIL timeout_frame: %0d samples not zero/forced, required 0", bad); end
            tests++; if (!obs_fs[0]) begin fails++; $display("FAIL timeout_fs: got %0b required 1", obs_fs[0]); end
            tests++;
            if (!obs_fs[128] || obs_frc[128]) begin fails++; $display("FAIL forced_clear: fs=%0b forced=%0b required 1 0", obs_fs[128], obs_frc[128]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        adc_data  = 12'd0;
        adc_valid = 1'b0;
        dec_ratio = 16'd1;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_sine_dec4();
        test_saturation();
        test_gapped();
        test_back_to_back_dc();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
